// File: rtl/expr_equiv_sweeper_if.sv
// Bundle between the equivalence sweeper and whoever drives it and hosts the two
// expression implementations: sweep control, vector/sample path and result outputs.
interface expr_equiv_sweeper_if #(
  parameter int N_IN = 4
);
  localparam int N_VEC = 2**N_IN;

  logic              start;
  logic              abort;
  logic [N_IN-1:0]   vec;
  logic              in_a;
  logic              in_b;
  logic              busy;
  logic              done;
  logic              equal;
  logic [N_IN:0]     mismatch_cnt;
  logic [N_IN-1:0]   first_bad;
  logic              first_bad_vld;
  logic [N_VEC-1:0]  tt_a;
  logic [N_VEC-1:0]  tt_b;

  modport master (
    output start, abort, in_a, in_b,
    input  vec, busy, done, equal, mismatch_cnt, first_bad, first_bad_vld, tt_a, tt_b
  );

  modport slave (
    input  start, abort, in_a, in_b,
    output vec, busy, done, equal, mismatch_cnt, first_bad, first_bad_vld, tt_a, tt_b
  );
endinterface

// File: rtl/expr_equiv_sweeper.sv
// Walks every input vector through two implementations of one boolean function,
// builds both truth tables and reports equivalence, mismatch count and first bad vector.
//
// state    | meaning
// S_IDLE   | waiting for start; results of the last sweep held
// S_SETTLE | vector driven, waiting SETTLE cycles for the expressions to settle
// S_SAMPLE | capture in_a/in_b for the current vector, then advance or finish
// S_DONE   | one-cycle completion, done pulse visible
module expr_equiv_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  expr_equiv_sweeper_if.slave bus
);
  localparam int N_VEC = 2**N_IN;
  localparam int CW    = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [N_IN-1:0]  r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_equal;
  logic [N_IN:0]    r_mis_cnt;
  logic [N_IN-1:0]  r_first_bad;
  logic             r_first_bad_vld;
  logic [N_VEC-1:0] r_tt_a;
  logic [N_VEC-1:0] r_tt_b;

  logic             w_last;
  logic             w_cnt_hit;
  logic             w_miss;
  logic [N_IN:0]    w_mis_nxt;

  assign w_last    = (r_vec == {N_IN{1'b1}});
  assign w_cnt_hit = (r_cnt == CNT_LAST);
  assign w_miss    = bus.in_a ^ bus.in_b;
  assign w_mis_nxt = r_mis_cnt + {{N_IN{1'b0}}, w_miss};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (bus.abort)      w_state_nxt = S_IDLE;
        else if (w_cnt_hit) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (bus.abort)   w_state_nxt = S_IDLE;
        else if (w_last) w_state_nxt = S_DONE;
        else             w_state_nxt = S_SETTLE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      r_vec           <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_equal         <= 1'b0;
      r_mis_cnt       <= '0;
      r_first_bad     <= '0;
      r_first_bad_vld <= 1'b0;
      r_tt_a          <= '0;
      r_tt_b          <= '0;
    end else begin
      r_state <= w_state_nxt;
      // busy/done come straight from the next state so they line up with r_state
      r_busy  <= (w_state_nxt == S_SETTLE) || (w_state_nxt == S_SAMPLE);
      r_done  <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_vec           <= '0;
            r_cnt           <= '0;
            r_equal         <= 1'b0;
            r_mis_cnt       <= '0;
            r_first_bad     <= '0;
            r_first_bad_vld <= 1'b0;
            r_tt_a          <= '0;
            r_tt_b          <= '0;
          end
        end
        S_SETTLE: begin
          if (!bus.abort) r_cnt <= r_cnt + CW'(1);
        end
        S_SAMPLE: begin
          if (!bus.abort) begin
            r_tt_a[r_vec] <= bus.in_a;
            r_tt_b[r_vec] <= bus.in_b;
            r_mis_cnt     <= w_mis_nxt;
            if (w_miss && !r_first_bad_vld) begin
              r_first_bad     <= r_vec;
              r_first_bad_vld <= 1'b1;
            end
            // equal is resolved on the final sample so it appears together with done
            if (w_last) begin
              r_equal <= (w_mis_nxt == '0);
            end else begin
              r_vec <= r_vec + N_IN'(1);
              r_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vec           = r_vec;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.equal         = r_equal;
  assign bus.mismatch_cnt  = r_mis_cnt;
  assign bus.first_bad     = r_first_bad;
  assign bus.first_bad_vld = r_first_bad_vld;
  assign bus.tt_a          = r_tt_a;
  assign bus.tt_b          = r_tt_b;
endmodule

// File: tb/tb_expr_equiv_sweeper.sv
// Directed bench for expr_equiv_sweeper: two instances (SETTLE=1 and SETTLE=3)
// driven by x&(~y|~w|~z) and several faulty simplified forms.
module tb_expr_equiv_sweeper;
  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mode1   = 0;
  int   n_done1 = 0;
  int   n_done2 = 0;
  int   de;

  expr_equiv_sweeper_if #(.N_IN(4)) b1 ();
  expr_equiv_sweeper_if #(.N_IN(4)) b2 ();

  expr_equiv_sweeper #(.N_IN(4), .SETTLE(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b1.slave)
  );
  expr_equiv_sweeper #(.N_IN(4), .SETTLE(3)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .bus(b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic f_ref(input logic [3:0] v);
    return v[3] & (~v[2] | ~v[1] | ~v[0]);
  endfunction

  // 0: correct, 1: stuck-at-0, 2: inverted at vec 15, 3: fully inverted
  function automatic logic f_b(input logic [3:0] v, input int m);
    case (m)
      1:       return 1'b0;
      2:       return (v == 4'd15) ? ~f_ref(v) : f_ref(v);
      3:       return ~f_ref(v);
      default: return f_ref(v);
    endcase
  endfunction

  assign b1.in_a = f_ref(b1.vec);
  assign b1.in_b = f_b(b1.vec, mode1);
  assign b2.in_a = f_ref(b2.vec);
  assign b2.in_b = f_ref(b2.vec);

  always @(negedge clk) begin
    if (b1.done) n_done1++;
    if (b2.done) n_done2++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) b1.start = v;
    else        b2.start = v;
  endtask

  task automatic check_res(input int d, input string tag, input logic [15:0] tta,
                           input logic [15:0] ttb, input int mc, input int fb,
                           input int fbv, input int eq);
    chk({tag, ".tt_a"},  (d == 0) ? b1.tt_a : b2.tt_a, tta);
    chk({tag, ".tt_b"},  (d == 0) ? b1.tt_b : b2.tt_b, ttb);
    chk({tag, ".mcnt"},  (d == 0) ? b1.mismatch_cnt : b2.mismatch_cnt, mc);
    chk({tag, ".fbad"},  (d == 0) ? b1.first_bad : b2.first_bad, fb);
    chk({tag, ".fbvld"}, (d == 0) ? b1.first_bad_vld : b2.first_bad_vld, fbv);
    chk({tag, ".equal"}, (d == 0) ? b1.equal : b2.equal, eq);
  endtask

  // Start is sampled at edge 0; returns the edge index after which done is seen.
  // A second start pulse is placed on edge poke_at (0 = none).
  task automatic run_sweep(input int d, input int poke_at, output int done_edge);
    done_edge = -1;
    set_start(d, 1'b1);
    for (int e = 0; e < 400; e++) begin
      @(posedge clk); #1;
      set_start(d, (e + 1 == poke_at));
      if (e == 0) begin
        chk("clr.busy", (d == 0) ? b1.busy : b2.busy, 1);
        chk("clr.vec",  (d == 0) ? b1.vec : b2.vec, 0);
        chk("clr.mcnt", (d == 0) ? b1.mismatch_cnt : b2.mismatch_cnt, 0);
        chk("clr.tt_b", (d == 0) ? b1.tt_b : b2.tt_b, 0);
      end
      if ((d == 0) ? b1.done : b2.done) begin
        done_edge = e;
        break;
      end
    end
    set_start(d, 1'b0);
    chk("done_seen", (done_edge >= 0), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    b1.start = 1'b0; b1.abort = 1'b0;
    b2.start = 1'b0; b2.abort = 1'b0;
    #12;
    chk("rst.vec",  b1.vec, 0);
    chk("rst.busy", b1.busy, 0);
    chk("rst.done", b1.done, 0);
    check_res(0, "rst", 16'h0000, 16'h0000, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    // equivalent forms, SETTLE=1
    mode1 = 0;
    run_sweep(0, 0, de);
    chk("eq.lat",  de, 32);
    chk("eq.vec",  b1.vec, 15);
    check_res(0, "eq", 16'h7F00, 16'h7F00, 0, 0, 0, 1);
    @(posedge clk); #1;
    chk("eq.done_1cyc", b1.done, 0);
    chk("eq.busy_idle", b1.busy, 0);

    // B stuck at 0
    mode1 = 1;
    run_sweep(0, 0, de);
    check_res(0, "sa0", 16'h7F00, 16'h0000, 7, 8, 1, 0);
    @(posedge clk); #1;

    // B inverted at the last vector, then back-to-back correct run
    mode1 = 2;
    run_sweep(0, 0, de);
    check_res(0, "v15", 16'h7F00, 16'hFF00, 1, 15, 1, 0);
    @(posedge clk); #1;
    mode1 = 0;
    run_sweep(0, 0, de);
    chk("b2b.lat", de, 32);
    check_res(0, "b2b", 16'h7F00, 16'h7F00, 0, 0, 0, 1);
    @(posedge clk); #1;

    // SETTLE=3 with a start pulse mid-sweep and another while in DONE
    run_sweep(1, 20, de);
    chk("s3.lat", de, 64);
    check_res(1, "s3", 16'h7F00, 16'h7F00, 0, 0, 0, 1);
    set_start(1, 1'b1);
    @(posedge clk); #1;
    set_start(1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("s3.no_restart", b2.busy, 0);
    chk("s3.done_count", n_done2, 1);

    // abort while vec=5, B fully inverted
    mode1 = 3;
    begin
      int n_before;
      bit seen;
      n_before = n_done1;
      seen = 1'b0;
      b1.start = 1'b1;
      for (int e = 0; e < 100; e++) begin
        @(posedge clk); #1;
        b1.start = 1'b0;
        if (b1.vec == 4'd5) begin
          seen = 1'b1;
          break;
        end
      end
      chk("ab.reach5", seen, 1);
      b1.abort = 1'b1;
      @(posedge clk); #1;
      b1.abort = 1'b0;
      chk("ab.busy", b1.busy, 0);
      chk("ab.vec",  b1.vec, 5);
      check_res(0, "ab", 16'h0000, 16'h001F, 5, 0, 1, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("ab.vec_hold", b1.vec, 5);
      chk("ab.no_done",  n_done1, n_before);
      b1.start = 1'b1;
      @(posedge clk); #1;
      b1.start = 1'b0;
      chk("ab.restart_vec",  b1.vec, 0);
      chk("ab.restart_busy", b1.busy, 1);
      b1.abort = 1'b1;
      @(posedge clk); #1;
      b1.abort = 1'b0;
    end

    // asynchronous reset while vec=9, then a clean sweep
    mode1 = 0;
    begin
      bit seen;
      seen = 1'b0;
      b1.start = 1'b1;
      for (int e = 0; e < 100; e++) begin
        @(posedge clk); #1;
        b1.start = 1'b0;
        if (b1.vec == 4'd9) begin
          seen = 1'b1;
          break;
        end
      end
      chk("rs.reach9", seen, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rs.vec",  b1.vec, 0);
      chk("rs.busy", b1.busy, 0);
      chk("rs.done", b1.done, 0);
      check_res(0, "rs", 16'h0000, 16'h0000, 0, 0, 0, 0);
      chk("rs.dut2_tt_a",  b2.tt_a, 0);
      chk("rs.dut2_equal", b2.equal, 0);
      #3 rst_n = 1'b1;
    end
    run_sweep(0, 0, de);
    chk("post.lat", de, 32);
    check_res(0, "post", 16'h7F00, 16'h7F00, 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
